mult_div_unit: RTL and testbench

Iterative multiply/divide unit producing HI/LO results for the multicycle CPU datapath, parametrised in operand width. Replaces single-cycle product/quotient logic with a start/busy/done handshake so the control unit can stall in a wait state. Supports signed and unsigned multiply and divide, with a divide-by-zero flag. Results feed the HI and LO inputs of the register write-data multiplexer.

---
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the multicycle datapath.
// Signed and unsigned shift-add multiply and restoring divide run on operand
// magnitudes. The result signs are applied once, in FIX. hi/lo/div_zero
// change only when an operation completes, so the register write-data mux
// always sees the last finished result.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

  stateT                state, nextState;
  logic                 isDiv;       // latched op[1]
  logic                 negRes;      // product / quotient must be negated
  logic                 negRem;      // remainder takes the sign of a
  logic                 zeroDiv;     // divide by zero pending for FIX
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     opnd;        // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0]   acc;         // mult: product/multiplier; div: low half is dividend -> quotient
  logic [WIDTH-1:0]     rem;         // partial remainder, always below the divisor

  // Request decode: magnitudes and signs of the incoming operands
  logic             signedIn, signA, signB, divZeroIn;
  logic [WIDTH-1:0] absA, absB;

  // Per-iteration datapath and FIX-time sign correction
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;      // WIDTH+1-bit trial partial remainder
  logic               fits;
  logic [2*WIDTH-1:0] prodRes;
  logic [WIDTH-1:0]   quoRes, remRes;

  assign busy = (state != IDLE);

  // Decode the request operands into magnitudes and sign flags
  always_comb begin
    signedIn  = ~op[0];
    signA     = signedIn & a[WIDTH-1];
    signB     = signedIn & b[WIDTH-1];
    absA      = signA ? -a : a;
    absB      = signB ? -b : b;
    divZeroIn = op[1] && (b == '0);
  end

  // One shift-add / restoring-divide step, and the signed final results
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    remShift = {rem, acc[WIDTH-1]};
    fits     = (remShift >= {1'b0, opnd});
    prodRes  = negRes ? -acc : acc;
    quoRes   = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remRes   = negRem ? -rem : rem;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = divZeroIn ? FIX : CALC;
      CALC:    if (count == '0) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      zeroDiv  <= 1'b0;
      count    <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          isDiv   <= op[1];
          negRes  <= signA ^ signB;
          negRem  <= signA;
          zeroDiv <= divZeroIn;
          count   <= CW'(WIDTH - 1);
          opnd    <= op[1] ? absB : absA;
          acc     <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
          rem     <= '0;
        end
        CALC: begin
          count <= count - 1'b1;
          if (!isDiv) begin
            acc <= {mulSum, acc[WIDTH-1:1]};
          end else begin
            rem              <= fits ? WIDTH'(remShift - {1'b0, opnd}) : remShift[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], fits};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (zeroDiv) begin
            div_zero <= 1'b1;
          end else begin
            div_zero <= 1'b0;
            if (isDiv) begin
              hi <= remRes;
              lo <= quoRes;
            end else begin
              hi <= prodRes[2*WIDTH-1:WIDTH];
              lo <= prodRes[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int nChecks = 0, nPass = 0;
  logic [W-1:0] mHi = '0, mLo = '0, oldHi, oldLo;
  logic         mDz = 1'b0, oldDz;
  int           expLat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; {mHi, mLo} = p; mDz = 1'b0; end
      2'd1: begin u = {32'b0, x} * {32'b0, y}; {mHi, mLo} = u; mDz = 1'b0; end
      2'd2: if (y == 0) mDz = 1'b1;
            else begin p = sx / sy; mLo = p[31:0]; p = sx % sy; mHi = p[31:0]; mDz = 1'b0; end
      default: if (y == 0) mDz = 1'b1;
            else begin mLo = x / y; mHi = x % y; mDz = 1'b0; end
    endcase
  endtask

  // Drive a request in the current cycle (called #1 after a rising edge)
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    oldHi = mHi; oldLo = mLo; oldDz = mDz;
    expLat = (o[1] && y == 0) ? 2 : W + 2;
    model(o, x, y);
  endtask

  // Wait for done (bounded) and check latency, held outputs and result
  task automatic waitDone(input string tag);
    int n;
    bit got, heldOk;
    n = 0; got = 0; heldOk = 1;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom); end
      if (done) got = 1;
      else if (!busy || hi !== oldHi || lo !== oldLo || div_zero !== oldDz) heldOk = 0;
    end
    chk({tag, ".lat"}, 64'(n), 64'(expLat));
    chk({tag, ".held"}, 64'(heldOk), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(mHi));
    chk({tag, ".lo"}, 64'(lo), 64'(mLo));
    chk({tag, ".dz"}, 64'(div_zero), 64'(mDz));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.dz", 64'(div_zero), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(2'd0, 32'hFFFFFFFD, 32'd7);       waitDone("mult_neg3x7");
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); waitDone("multu_max");
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF); waitDone("mult_m1m1");
    issue(2'd2, 32'hFFFFFFF9, 32'd2);       waitDone("div_neg7_2");
    issue(2'd3, 32'd7, 32'd2);              waitDone("divu_7_2");
    issue(2'd2, 32'd5, 32'd0);              waitDone("div_by0");
    issue(2'd3, 32'd9, 32'd3);              waitDone("divu_9_3");
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF); waitDone("div_minneg");

    // Ignored restart while busy, then asynchronous reset mid-CALC
    issue(2'd0, 32'd1234, 32'd5678);
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'd1; a = 32'd99; b = 32'd77;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midop.busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async.busy", 64'(busy), 64'd0);
    chk("async.done", 64'(done), 64'd0);
    chk("async.hi", 64'(hi), 64'd0);
    chk("async.lo", 64'(lo), 64'd0);
    chk("async.dz", 64'(div_zero), 64'd0);
    mHi = '0; mLo = '0; mDz = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    issue(2'd3, 32'd100, 32'd7);            waitDone("divu_100_7");

    // Back-to-back: new start in the done cycle
    issue(2'd1, 32'd3, 32'd4);              waitDone("b2b_multu");
    issue(2'd3, 32'd9, 32'd2);              waitDone("b2b_divu");

    // Randomized operations, mixed gaps and back-to-back issue
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] x, y;
      logic [1:0]   o;
      o = 2'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = $urandom_range(0, 50); y = $urandom_range(1, 9); end
        2: begin x = 32'h80000000; y = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000; end
        3: begin x = -($urandom_range(1, 1000)); y = $urandom_range(1, 13); end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(o, x, y);
      waitDone($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
